// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pixel path: the lcdbpp mode encoding,
// per-mode pixel widths and helpers that say how a 32-bit frame-buffer
// word is carved into pixels.
package lcd_pkg;

   typedef enum logic [2:0] {
      BPP_1    = 3'b000,
      BPP_2    = 3'b001,
      BPP_4    = 3'b010,
      BPP_8    = 3'b011,
      BPP_1555 = 3'b100,
      BPP_24   = 3'b101,
      BPP_565  = 3'b110,
      BPP_444  = 3'b111
   } lcdBpp_e;

   typedef enum logic {
      ST_EMPTY  = 1'b0,
      ST_UNPACK = 1'b1
   } unpackState_e;

   localparam int WORD_BITS   = 32;
   localparam int PIXBITS_1   = 1;
   localparam int PIXBITS_2   = 2;
   localparam int PIXBITS_4   = 4;
   localparam int PIXBITS_8   = 8;
   localparam int PIXBITS_16  = 16;
   localparam int PIXBITS_24  = 24;
   localparam int PIXBITS_12  = 12;

   // Number of pixels carried by one frame-buffer word in the given mode.
   // 12 bpp pixels sit one per half-word, 24 bpp takes the whole word.
   function automatic logic [5:0] pixelsPerWord(input lcdBpp_e mode);
      logic [5:0] count;
      case (mode)
         BPP_1:    count = 6'(WORD_BITS / PIXBITS_1);
         BPP_2:    count = 6'(WORD_BITS / PIXBITS_2);
         BPP_4:    count = 6'(WORD_BITS / PIXBITS_4);
         BPP_8:    count = 6'(WORD_BITS / PIXBITS_8);
         BPP_1555: count = 6'(WORD_BITS / PIXBITS_16);
         BPP_565:  count = 6'(WORD_BITS / PIXBITS_16);
         BPP_444:  count = 6'(WORD_BITS / PIXBITS_16);
         BPP_24:   count = 6'd1;
         default:  count = 6'd0;
      endcase
      return count;
   endfunction

   // Bit distance between consecutive pixels inside a word (the slot).
   function automatic logic [5:0] slotWidth(input lcdBpp_e mode);
      logic [5:0] width;
      case (mode)
         BPP_1:    width = 6'(PIXBITS_1);
         BPP_2:    width = 6'(PIXBITS_2);
         BPP_4:    width = 6'(PIXBITS_4);
         BPP_8:    width = 6'(PIXBITS_8);
         BPP_1555: width = 6'(PIXBITS_16);
         BPP_565:  width = 6'(PIXBITS_16);
         BPP_444:  width = 6'(PIXBITS_16);
         BPP_24:   width = 6'(WORD_BITS);
         default:  width = 6'(WORD_BITS);
      endcase
      return width;
   endfunction

endpackage

// File: rtl/lcd_pixel_unpacker_if.sv
// Handshake bundle between a frame-buffer word source and the pixel
// consumer.  The master side feeds words and takes pixels; the slave side
// is the unpacker.
interface lcd_pixel_unpacker_if;

   logic [31:0] fb_data_in;
   logic        fb_valid;
   logic        fb_ready;
   logic [2:0]  lcdbpp;
   logic        flush;
   logic [23:0] pix_out;
   logic        pix_is_index;
   logic        pix_valid;
   logic        pix_ready;

   modport master (
      output fb_data_in, fb_valid, lcdbpp, flush, pix_ready,
      input  fb_ready, pix_out, pix_is_index, pix_valid
   );

   modport slave (
      input  fb_data_in, fb_valid, lcdbpp, flush, pix_ready,
      output fb_ready, pix_out, pix_is_index, pix_valid
   );

endinterface

// File: rtl/lcd_pixel_expand.sv
// Turns one raw pixel field (already aligned to bit 0) into the 24-bit
// RGB888 form, or a zero-extended palette index for the 1/2/4/8 bpp modes.
// Purely combinational so the encoder side can reuse it as is.
module lcd_pixel_expand
   import lcd_pkg::*;
(
   input  logic [23:0] i_raw,
   input  lcdBpp_e     i_mode,
   output logic [23:0] o_pix,
   output logic        o_isIndex
);

   logic [11:0] w_rgb444;

   assign w_rgb444 = i_raw[PIXBITS_12-1:0];

   // Narrow components are widened by repeating their top bits in the
   // freed LSBs so full-scale stays full-scale and zero stays zero.
   function automatic logic [7:0] widen5(input logic [4:0] c);
      return {c, c[4:2]};
   endfunction

   function automatic logic [7:0] widen6(input logic [5:0] c);
      return {c, c[5:4]};
   endfunction

   function automatic logic [7:0] widen4(input logic [3:0] c);
      return {c, c};
   endfunction

   // Select the field layout for the mode and build the output pixel.
   always_comb begin
      o_pix     = '0;
      o_isIndex = 1'b0;
      case (i_mode)
         BPP_1: begin
            o_pix     = 24'(i_raw[PIXBITS_1-1:0]);
            o_isIndex = 1'b1;
         end
         BPP_2: begin
            o_pix     = 24'(i_raw[PIXBITS_2-1:0]);
            o_isIndex = 1'b1;
         end
         BPP_4: begin
            o_pix     = 24'(i_raw[PIXBITS_4-1:0]);
            o_isIndex = 1'b1;
         end
         BPP_8: begin
            o_pix     = 24'(i_raw[PIXBITS_8-1:0]);
            o_isIndex = 1'b1;
         end
         BPP_1555: begin
            o_pix = {widen5(i_raw[14:10]), widen5(i_raw[9:5]), widen5(i_raw[4:0])};
         end
         BPP_565: begin
            o_pix = {widen5(i_raw[15:11]), widen6(i_raw[10:5]), widen5(i_raw[4:0])};
         end
         BPP_444: begin
            o_pix = {widen4(w_rgb444[11:8]), widen4(w_rgb444[7:4]), widen4(w_rgb444[3:0])};
         end
         BPP_24: begin
            o_pix = i_raw[PIXBITS_24-1:0];
         end
         default: begin
            o_pix     = '0;
            o_isIndex = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/lcd_pixel_unpacker.sv
// Accepts packed 32-bit frame-buffer words and streams them out one pixel
// per clock.  The mode is latched with each word; the buffered word is
// shifted by one pixel slot per consumed pixel, and the next pixel is
// expanded ahead of time into an output register so pix_out never sees a
// combinational path from fb_data_in.
module lcd_pixel_unpacker
   import lcd_pkg::*;
#(
   parameter bit PIX_MSB_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fb_data_in,
   input  logic        fb_valid,
   output logic        fb_ready,
   input  logic [2:0]  lcdbpp,
   input  logic        flush,
   output logic [23:0] pix_out,
   output logic        pix_is_index,
   output logic        pix_valid,
   input  logic        pix_ready
);

   unpackState_e r_state;
   unpackState_e w_nextState;
   logic [5:0]   r_count;
   logic [31:0]  r_word;
   lcdBpp_e      r_mode;
   logic [23:0]  r_pixOut;
   logic         r_pixIsIndex;
   logic         r_resetHold;

   lcdBpp_e      w_inMode;
   lcdBpp_e      w_srcMode;
   logic         w_fbReady;
   logic         w_pixValid;
   logic         w_accept;
   logic         w_consume;
   logic         w_lastPix;
   logic [5:0]   w_curSlot;
   logic [5:0]   w_srcSlot;
   logic [31:0]  w_shifted;
   logic [31:0]  w_srcWord;
   logic [23:0]  w_raw;
   logic [23:0]  w_expPix;
   logic         w_expIdx;

   assign w_inMode   = lcdBpp_e'(lcdbpp);
   assign w_pixValid = (r_state == ST_UNPACK) && !rst;
   assign w_lastPix  = (r_count == 6'd1);

   // A new word may enter when idle, or while the last pixel of the current
   // word is leaving so words stream back to back; flush, reset and the
   // first cycle after reset always block acceptance.
   assign w_fbReady = !rst && !flush && !r_resetHold &&
                      ((r_state == ST_EMPTY) ||
                       ((r_state == ST_UNPACK) && w_lastPix && pix_ready));

   assign w_accept  = fb_valid && w_fbReady;
   assign w_consume = w_pixValid && pix_ready;

   // Advance the buffered word by one pixel slot in the configured order.
   assign w_curSlot = slotWidth(r_mode);
   assign w_shifted = PIX_MSB_FIRST ? (r_word << w_curSlot) : (r_word >> w_curSlot);

   // The pixel to present next comes from the incoming word on acceptance,
   // otherwise from the word after it has been advanced.
   assign w_srcWord = w_accept ? fb_data_in : w_shifted;
   assign w_srcMode = w_accept ? w_inMode : r_mode;
   assign w_srcSlot = slotWidth(w_srcMode);
   assign w_raw     = 24'(PIX_MSB_FIRST ? (w_srcWord >> (6'd32 - w_srcSlot)) : w_srcWord);

   lcd_pixel_expand u_expand (
      .i_raw     (w_raw),
      .i_mode    (w_srcMode),
      .o_pix     (w_expPix),
      .o_isIndex (w_expIdx)
   );

   // State register for the EMPTY/UNPACK controller.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic; flush overrides every handshake.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_nextState = ST_UNPACK;
            end
         end
         ST_UNPACK: begin
            if (w_consume && w_lastPix && !w_accept) begin
               w_nextState = ST_EMPTY;
            end
         end
         default: begin
            w_nextState = ST_EMPTY;
         end
      endcase
      if (flush) begin
         w_nextState = ST_EMPTY;
      end
   end

   // Keeps fb_ready low for the first cycle after reset is released.
   always_ff @(posedge clk) begin
      r_resetHold <= rst;
   end

   // Word buffer, latched mode, remaining count and the registered pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_word       <= '0;
         r_mode       <= BPP_1;
         r_count      <= '0;
         r_pixOut     <= '0;
         r_pixIsIndex <= 1'b0;
      end else if (flush) begin
         r_count <= '0;
      end else if (w_accept) begin
         r_word       <= fb_data_in;
         r_mode       <= w_inMode;
         r_count      <= pixelsPerWord(w_inMode);
         r_pixOut     <= w_expPix;
         r_pixIsIndex <= w_expIdx;
      end else if (w_consume) begin
         r_word       <= w_shifted;
         r_count      <= r_count - 6'd1;
         r_pixOut     <= w_expPix;
         r_pixIsIndex <= w_expIdx;
      end
   end

   assign fb_ready     = w_fbReady;
   assign pix_valid    = w_pixValid;
   assign pix_out      = rst ? 24'd0 : r_pixOut;
   assign pix_is_index = !rst && r_pixIsIndex;

endmodule

// File: tb/tb_lcd_pixel_unpacker.sv
// Self-checking bench for lcd_pixel_unpacker (LSB-first build).  A monitor
// pushes the expected pixels of every accepted word into a queue from an
// independent model and pops them as the DUT hands pixels out; a vector
// table and a few hand sequences cover latency, streaming, stalls, flush,
// mid-word mode changes and reset.
module tb_lcd_pixel_unpacker;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   lcd_pixel_unpacker_if bus();

   lcd_pixel_unpacker #(.PIX_MSB_FIRST(1'b0)) dut (
      .clk          (clk),
      .rst          (rst),
      .fb_data_in   (bus.fb_data_in),
      .fb_valid     (bus.fb_valid),
      .fb_ready     (bus.fb_ready),
      .lcdbpp       (bus.lcdbpp),
      .flush        (bus.flush),
      .pix_out      (bus.pix_out),
      .pix_is_index (bus.pix_is_index),
      .pix_valid    (bus.pix_valid),
      .pix_ready    (bus.pix_ready)
   );

   typedef struct packed {
      logic        isIdx;
      logic [23:0] pix;
   } pixExp_t;

   typedef struct {
      logic [2:0]  mode;
      logic [31:0] word;
      logic [23:0] expFirst;
      logic        expIdx;
      int          expCount;
   } vec_t;

   pixExp_t expQ[$];
   vec_t    vecs[11];
   int      total    = 0;
   int      bad      = 0;
   int      consumed = 0;

   // One comparison: count it and report a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   task automatic reportTimeout(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: timed out", name);
   endtask

   function automatic logic [7:0] widen5(input int x);
      return 8'((x << 3) | (x >> 2));
   endfunction

   function automatic logic [7:0] widen6(input int x);
      return 8'((x << 2) | (x >> 4));
   endfunction

   function automatic logic [7:0] widen4(input int x);
      return 8'(x * 17);
   endfunction

   function automatic int modelCount(input logic [2:0] mode);
      case (mode)
         3'd0: return 32;
         3'd1: return 16;
         3'd2: return 8;
         3'd3: return 4;
         3'd5: return 1;
         default: return 2;
      endcase
   endfunction

   // Reference pixel k of word w for LSB-first unpacking.
   function automatic pixExp_t modelPix(input logic [2:0] mode, input logic [31:0] w, input int k);
      pixExp_t e;
      int f;
      e.isIdx = 1'b0;
      e.pix   = '0;
      f       = int'((w >> (16 * k)) & 32'hFFFF);
      case (mode)
         3'd0: begin e.isIdx = 1'b1; e.pix = 24'((w >> k) & 32'h1); end
         3'd1: begin e.isIdx = 1'b1; e.pix = 24'((w >> (2 * k)) & 32'h3); end
         3'd2: begin e.isIdx = 1'b1; e.pix = 24'((w >> (4 * k)) & 32'hF); end
         3'd3: begin e.isIdx = 1'b1; e.pix = 24'((w >> (8 * k)) & 32'hFF); end
         3'd4: e.pix = {widen5((f >> 10) & 31), widen5((f >> 5) & 31), widen5(f & 31)};
         3'd5: e.pix = w[23:0];
         3'd6: e.pix = {widen5((f >> 11) & 31), widen6((f >> 5) & 63), widen5(f & 31)};
         default: e.pix = {widen4((f >> 8) & 15), widen4((f >> 4) & 15), widen4(f & 15)};
      endcase
      return e;
   endfunction

   // Scoreboard: check consumed pixels, drop on flush/reset, queue on accept.
   always @(negedge clk) begin
      pixExp_t e;
      if (rst === 1'b1) begin
         expQ.delete();
      end else begin
         if (bus.pix_valid && bus.pix_ready) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected pixel: got 0x%0h, want none", bus.pix_out);
            end else begin
               e = expQ.pop_front();
               checkOutput("pixel value", 32'(bus.pix_out), 32'(e.pix));
               checkOutput("pixel kind", 32'(bus.pix_is_index), 32'(e.isIdx));
            end
            consumed++;
         end
         if (bus.flush) begin
            expQ.delete();
         end
         if (bus.fb_valid && bus.fb_ready) begin
            for (int k = 0; k < modelCount(bus.lcdbpp); k++) begin
               expQ.push_back(modelPix(bus.lcdbpp, bus.fb_data_in, k));
            end
         end
      end
   end

   // Offer one word and return #1 after the edge that accepted it.
   task automatic applyStimulus(input logic [2:0] mode, input logic [31:0] word);
      bit ok;
      ok = 1'b0;
      bus.fb_data_in = word;
      bus.lcdbpp     = mode;
      bus.fb_valid   = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (bus.fb_ready) ok = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.fb_valid = 1'b0;
      if (!ok) reportTimeout("word accept");
   endtask

   // Wait until all expected pixels are out and the unpacker is idle.
   task automatic waitDrain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clk);
         #1;
         if (!bus.pix_valid && expQ.size() == 0) done = 1'b1;
      end
      if (!done) reportTimeout("drain");
   endtask

   initial begin
      int  startCons;
      bit  ok;
      bit  stalledPrev;
      logic [23:0] held;
      logic pattern[4];

      vecs[0]  = '{3'd5, 32'hFF123456, 24'h123456, 1'b0, 1};
      vecs[1]  = '{3'd6, 32'h001FF800, 24'hFF0000, 1'b0, 2};
      vecs[2]  = '{3'd6, 32'h000007E0, 24'h00FF00, 1'b0, 2};
      vecs[3]  = '{3'd4, 32'h00007FFF, 24'hFFFFFF, 1'b0, 2};
      vecs[4]  = '{3'd4, 32'h00008000, 24'h000000, 1'b0, 2};
      vecs[5]  = '{3'd4, 32'h00004000, 24'h840000, 1'b0, 2};
      vecs[6]  = '{3'd7, 32'h0ABC0123, 24'h112233, 1'b0, 2};
      vecs[7]  = '{3'd3, 32'h11223344, 24'h000044, 1'b1, 4};
      vecs[8]  = '{3'd2, 32'h87654321, 24'h000001, 1'b1, 8};
      vecs[9]  = '{3'd1, 32'hFFFFFFFE, 24'h000002, 1'b1, 16};
      vecs[10] = '{3'd0, 32'h00000005, 24'h000001, 1'b1, 32};
      pattern  = '{1'b1, 1'b0, 1'b0, 1'b1};

      rst            = 1'b1;
      bus.fb_data_in = '0;
      bus.fb_valid   = 1'b0;
      bus.lcdbpp     = 3'd0;
      bus.flush      = 1'b0;
      bus.pix_ready  = 1'b1;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset pix_valid", 32'(bus.pix_valid), 32'd0);
      checkOutput("reset fb_ready", 32'(bus.fb_ready), 32'd0);
      checkOutput("reset pix_out", 32'(bus.pix_out), 32'd0);
      checkOutput("reset pix_is_index", 32'(bus.pix_is_index), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("post-reset ready hold", 32'(bus.fb_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("ready after reset", 32'(bus.fb_ready), 32'd1);

      // Vector table: latency-1 first pixel, kind, and pixels per word.
      for (int i = 0; i < 11; i++) begin
         startCons = consumed;
         applyStimulus(vecs[i].mode, vecs[i].word);
         checkOutput($sformatf("vec%0d latency", i), 32'(bus.pix_valid), 32'd1);
         checkOutput($sformatf("vec%0d first pixel", i), 32'(bus.pix_out), 32'(vecs[i].expFirst));
         checkOutput($sformatf("vec%0d index flag", i), 32'(bus.pix_is_index), 32'(vecs[i].expIdx));
         waitDrain();
         checkOutput($sformatf("vec%0d pixel count", i), 32'(consumed - startCons), 32'(vecs[i].expCount));
      end

      // Streaming 1 bpp: fb_ready only on pixel 32, next word without a gap.
      bus.fb_data_in = 32'h00000005;
      bus.lcdbpp     = 3'd0;
      bus.fb_valid   = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (bus.fb_ready) ok = 1'b1;
      end
      if (!ok) reportTimeout("stream accept");
      @(posedge clk);
      #1;
      bus.fb_data_in = 32'h00000003;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         checkOutput($sformatf("stream ready pix%0d", i), 32'(bus.fb_ready), 32'(i == 31));
         @(posedge clk);
         #1;
      end
      bus.fb_valid = 1'b0;
      checkOutput("stream no gap valid", 32'(bus.pix_valid), 32'd1);
      checkOutput("stream next pixel0", 32'(bus.pix_out), 32'd1);
      waitDrain();

      // Backpressure: 4 bpp with pix_ready 1,0,0,1; stalled pixels hold.
      startCons   = consumed;
      stalledPrev = 1'b0;
      held        = '0;
      applyStimulus(3'd2, 32'h87654321);
      for (int c = 0; c < 64 && (consumed - startCons) < 8; c++) begin
         bus.pix_ready = pattern[c % 4];
         @(negedge clk);
         if (stalledPrev) checkOutput("stall hold", 32'(bus.pix_out), 32'(held));
         stalledPrev = bus.pix_valid && !bus.pix_ready;
         held        = bus.pix_out;
         @(posedge clk);
         #1;
      end
      bus.pix_ready = 1'b1;
      waitDrain();
      checkOutput("backpressure count", 32'(consumed - startCons), 32'd8);

      // Flush after 2 of 4 pixels; a word offered during flush waits.
      startCons = consumed;
      applyStimulus(3'd3, 32'h44332211);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      bus.flush      = 1'b1;
      bus.pix_ready  = 1'b0;
      bus.fb_data_in = 32'hDDCCBBAA;
      bus.lcdbpp     = 3'd3;
      bus.fb_valid   = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("flush empties", 32'(bus.pix_valid), 32'd0);
      @(negedge clk);
      checkOutput("flush blocks accept", 32'(bus.fb_ready), 32'd0);
      @(posedge clk);
      #1;
      bus.flush     = 1'b0;
      bus.pix_ready = 1'b1;
      checkOutput("no accept during flush", 32'(bus.pix_valid), 32'd0);
      @(posedge clk);
      #1;
      bus.fb_valid = 1'b0;
      checkOutput("after flush valid", 32'(bus.pix_valid), 32'd1);
      checkOutput("after flush pixel0", 32'(bus.pix_out), 32'hAA);
      waitDrain();
      checkOutput("flush pixel count", 32'(consumed - startCons), 32'd6);

      // Mode change mid-word stays 8 bpp.
      startCons = consumed;
      applyStimulus(3'd3, 32'h44332211);
      bus.lcdbpp = 3'b101;
      @(posedge clk);
      #1;
      checkOutput("mode change pixel1", 32'(bus.pix_out), 32'h22);
      checkOutput("mode change kind", 32'(bus.pix_is_index), 32'd1);
      waitDrain();
      checkOutput("mode change count", 32'(consumed - startCons), 32'd4);

      // Reset mid-word drops the word; no accept right after release.
      applyStimulus(3'd2, 32'h87654321);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("mid reset pix_valid", 32'(bus.pix_valid), 32'd0);
      checkOutput("mid reset pix_out", 32'(bus.pix_out), 32'd0);
      @(posedge clk);
      #1;
      rst            = 1'b0;
      bus.fb_data_in = 32'h000000AB;
      bus.lcdbpp     = 3'd3;
      bus.fb_valid   = 1'b1;
      checkOutput("reset edge pix_valid", 32'(bus.pix_valid), 32'd0);
      checkOutput("reset release ready", 32'(bus.fb_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("no accept after reset", 32'(bus.pix_valid), 32'd0);
      checkOutput("ready rises", 32'(bus.fb_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.fb_valid = 1'b0;
      checkOutput("after reset pixel0", 32'(bus.pix_out), 32'hAB);
      waitDrain();

      checkOutput("queue empty at end", 32'(expQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
